// File: rtl/lc3b_types.sv
// Shared types for the LC-3b pipeline: datapath words, write masks and MEM-stage states.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [2:0] {
        IDLE,
        PTR,
        ACCESS,
        FINAL,
        DONE
    } lc3b_mem_state;

    localparam lc3b_mem_wmask MASK_ALL = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; asynchronous active-high clear.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: single cache access for LDR/STR/LDB/STB/TRAP, pointer-then-data for LDI/STI.
// Stalls upstream until the access completes; a flushed request still finishes its cache handshake.
module mem_access_unit
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  indirect_enable,
    input  logic [1:0]            mem_byte_enable,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  hold,
    input  logic                  dcache_resp,
    input  logic [DATA_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_read,
    output logic                  dcache_write,
    output logic [ADDR_WIDTH-1:0] dcache_address,
    output logic [DATA_WIDTH-1:0] dcache_wdata,
    output logic [1:0]            dcache_byte_enable,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CNT_WIDTH-1:0]  access_count
);

    lc3b_mem_state         state;
    lc3b_mem_state         next_state;
    logic [ADDR_WIDTH-1:0] pointer;
    logic                  need;
    logic                  ptr_load;
    logic                  rdata_load;
    logic                  resp_accept;

    assign need  = valid & (mem_read | mem_write | indirect_enable);
    assign stall = need & (state != DONE);

    // A dropped valid means the instruction was flushed: finish the
    // outstanding handshake, then go straight back to IDLE.
    always_comb begin
        next_state         = state;
        dcache_read        = 1'b0;
        dcache_write       = 1'b0;
        dcache_address     = '0;
        dcache_wdata       = '0;
        dcache_byte_enable = MASK_ALL;
        ptr_load           = 1'b0;
        rdata_load         = 1'b0;
        resp_accept        = 1'b0;

        case (state)
            IDLE: begin
                if (need) begin
                    next_state = indirect_enable ? PTR : ACCESS;
                end
            end

            PTR: begin
                dcache_read    = 1'b1;
                dcache_address = addr;
                if (dcache_resp) begin
                    resp_accept = 1'b1;
                    ptr_load    = 1'b1;
                    next_state  = valid ? FINAL : IDLE;
                end
            end

            ACCESS: begin
                dcache_address = addr;
                if (mem_read) begin
                    dcache_read = 1'b1;
                end else begin
                    dcache_write       = 1'b1;
                    dcache_wdata       = wdata;
                    dcache_byte_enable = mem_byte_enable;
                end
                if (dcache_resp) begin
                    resp_accept = 1'b1;
                    rdata_load  = mem_read;
                    next_state  = valid ? DONE : IDLE;
                end
            end

            FINAL: begin
                dcache_address = pointer;
                if (mem_read) begin
                    dcache_read = 1'b1;
                end else begin
                    dcache_write       = 1'b1;
                    dcache_wdata       = wdata;
                    dcache_byte_enable = mem_byte_enable;
                end
                if (dcache_resp) begin
                    resp_accept = 1'b1;
                    rdata_load  = mem_read;
                    next_state  = valid ? DONE : IDLE;
                end
            end

            DONE: begin
                if (!hold) begin
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pointer <= '0;
            rdata   <= '0;
        end else begin
            state <= next_state;
            if (ptr_load) begin
                pointer <= ADDR_WIDTH'(dcache_rdata);
            end
            if (rdata_load) begin
                rdata <= dcache_rdata;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_access_count (
        .clk   (clk),
        .reset (reset),
        .inc   (resp_accept),
        .count (access_count)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; a narrow access counter lets saturation be reached quickly.
module tb_mem_access_unit;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid;
    logic          mem_read;
    logic          mem_write;
    logic          indirect_enable;
    logic [1:0]    mem_byte_enable;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          hold;
    logic          dcache_resp;
    logic [DW-1:0] dcache_rdata;
    logic          dcache_read;
    logic          dcache_write;
    logic [AW-1:0] dcache_address;
    logic [DW-1:0] dcache_wdata;
    logic [1:0]    dcache_byte_enable;
    logic          stall;
    logic [DW-1:0] rdata;
    logic [CW-1:0] access_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .valid              (valid),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .indirect_enable    (indirect_enable),
        .mem_byte_enable    (mem_byte_enable),
        .addr               (addr),
        .wdata              (wdata),
        .hold               (hold),
        .dcache_resp        (dcache_resp),
        .dcache_rdata       (dcache_rdata),
        .dcache_read        (dcache_read),
        .dcache_write       (dcache_write),
        .dcache_address     (dcache_address),
        .dcache_wdata       (dcache_wdata),
        .dcache_byte_enable (dcache_byte_enable),
        .stall              (stall),
        .rdata              (rdata),
        .access_count       (access_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        indirect_enable = 1'b0; mem_byte_enable = 2'b11; addr = '0; wdata = '0;
        hold = 1'b0; dcache_resp = 1'b0; dcache_rdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_read", dcache_read, 0);
        chk("rst_write", dcache_write, 0);
        chk("rst_stall", stall, 0);
        chk("rst_addr", dcache_address, 0);
        chk("rst_wdata", dcache_wdata, 0);
        chk("rst_be", dcache_byte_enable, 2'b11);
        chk("rst_rdata", rdata, 0);
        chk("rst_count", access_count, 0);
        @(negedge clk); reset = 1'b0;

        // LDR 0x1000, three wait cycles, data 0xBEEF
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; addr = 16'h1000; #1;
        chk("ldr_idle_stall", stall, 1);
        chk("ldr_idle_read", dcache_read, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("ldr_wait_read", dcache_read, 1);
            chk("ldr_wait_addr", dcache_address, 16'h1000);
            chk("ldr_wait_stall", stall, 1);
        end
        @(negedge clk); dcache_resp = 1'b1; dcache_rdata = 16'hBEEF; #1;
        chk("ldr_resp_read", dcache_read, 1);
        chk("ldr_resp_stall", stall, 1);
        @(negedge clk); dcache_resp = 1'b0; dcache_rdata = '0; #1;
        chk("ldr_done_stall", stall, 0);
        chk("ldr_done_read", dcache_read, 0);
        chk("ldr_rdata", rdata, 16'hBEEF);
        chk("ldr_count", access_count, 1);
        valid = 1'b0; mem_read = 1'b0;
        @(negedge clk); #1;
        chk("ldr_idle_after", dcache_read, 0);

        // Reset while ACCESS is reading; in-flight response discarded
        valid = 1'b1; mem_read = 1'b1; addr = 16'h1000;
        @(negedge clk); #1;
        chk("rstmid_pre_read", dcache_read, 1);
        reset = 1'b1; dcache_resp = 1'b1; dcache_rdata = 16'h9999; #1;
        chk("rstmid_read", dcache_read, 0);
        chk("rstmid_count", access_count, 0);
        chk("rstmid_rdata", rdata, 0);
        valid = 1'b0; mem_read = 1'b0;
        @(negedge clk); reset = 1'b0; dcache_resp = 1'b0; dcache_rdata = '0; #1;
        chk("rstmid_count_after", access_count, 0);
        chk("rstmid_idle_stall", stall, 0);

        // STB 0x2001, wdata 0x00AB, mask 2'b10, zero-wait
        @(negedge clk); valid = 1'b1; mem_write = 1'b1; addr = 16'h2001;
        wdata = 16'h00AB; mem_byte_enable = 2'b10; #1;
        chk("stb_idle_stall", stall, 1);
        chk("stb_idle_write", dcache_write, 0);
        @(negedge clk); dcache_resp = 1'b1; dcache_rdata = 16'hDEAD; #1;
        chk("stb_write", dcache_write, 1);
        chk("stb_read", dcache_read, 0);
        chk("stb_addr", dcache_address, 16'h2001);
        chk("stb_wdata", dcache_wdata, 16'h00AB);
        chk("stb_be", dcache_byte_enable, 2'b10);
        chk("stb_stall", stall, 1);
        @(negedge clk); dcache_resp = 1'b0; dcache_rdata = '0; #1;
        chk("stb_done_stall", stall, 0);
        chk("stb_done_write", dcache_write, 0);
        chk("stb_rdata_kept", rdata, 0);
        chk("stb_count", access_count, 1);
        valid = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b11;

        // LDI 0x3000 -> pointer 0x4000 -> data 0x1234
        @(negedge clk); valid = 1'b1; indirect_enable = 1'b1; mem_read = 1'b1; addr = 16'h3000; #1;
        chk("ldi_idle_stall", stall, 1);
        @(negedge clk); dcache_resp = 1'b1; dcache_rdata = 16'h4000; #1;
        chk("ldi_ptr_read", dcache_read, 1);
        chk("ldi_ptr_addr", dcache_address, 16'h3000);
        chk("ldi_ptr_stall", stall, 1);
        @(negedge clk); dcache_rdata = 16'h1234; #1;
        chk("ldi_fin_read", dcache_read, 1);
        chk("ldi_fin_addr", dcache_address, 16'h4000);
        chk("ldi_fin_stall", stall, 1);
        @(negedge clk); dcache_resp = 1'b0; dcache_rdata = '0; #1;
        chk("ldi_done_stall", stall, 0);
        chk("ldi_rdata", rdata, 16'h1234);
        chk("ldi_count", access_count, 3);
        valid = 1'b0; indirect_enable = 1'b0; mem_read = 1'b0;

        // STI 0x3000 -> pointer 0x5000, write 0x7777 mask 2'b11
        @(negedge clk); valid = 1'b1; indirect_enable = 1'b1; mem_write = 1'b1;
        addr = 16'h3000; wdata = 16'h7777; mem_byte_enable = 2'b11; #1;
        chk("sti_idle_stall", stall, 1);
        @(negedge clk); dcache_resp = 1'b1; dcache_rdata = 16'h5000; #1;
        chk("sti_ptr_read", dcache_read, 1);
        chk("sti_ptr_write", dcache_write, 0);
        chk("sti_ptr_addr", dcache_address, 16'h3000);
        @(negedge clk); dcache_rdata = 16'hFFFF; #1;
        chk("sti_fin_write", dcache_write, 1);
        chk("sti_fin_read", dcache_read, 0);
        chk("sti_fin_addr", dcache_address, 16'h5000);
        chk("sti_fin_wdata", dcache_wdata, 16'h7777);
        chk("sti_fin_be", dcache_byte_enable, 2'b11);
        @(negedge clk); dcache_resp = 1'b0; dcache_rdata = '0; #1;
        chk("sti_done_stall", stall, 0);
        chk("sti_rdata_kept", rdata, 16'h1234);
        chk("sti_count", access_count, 5);

        // DONE held for four cycles, stray response ignored
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); dcache_resp = (i == 1); #1;
            chk("hold_stall", stall, 0);
            chk("hold_read", dcache_read, 0);
            chk("hold_write", dcache_write, 0);
        end
        dcache_resp = 1'b0; hold = 1'b0;
        @(negedge clk); #1;
        chk("hold_count", access_count, 5);
        chk("hold_release_idle_stall", stall, 1);
        chk("hold_release_idle_write", dcache_write, 0);
        valid = 1'b0; indirect_enable = 1'b0; mem_write = 1'b0; #1;
        chk("hold_idle_nostall", stall, 0);

        // Flush: valid drops while ACCESS waits; rdata still updated, then IDLE
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; addr = 16'h6000;
        @(negedge clk); #1;
        chk("flush_read", dcache_read, 1);
        valid = 1'b0; dcache_resp = 1'b1; dcache_rdata = 16'h5A5A; #1;
        chk("flush_read_held", dcache_read, 1);
        chk("flush_addr_held", dcache_address, 16'h6000);
        chk("flush_stall", stall, 0);
        @(negedge clk); dcache_resp = 1'b0; dcache_rdata = '0; valid = 1'b1; addr = 16'h7000; #1;
        chk("flush_idle_stall", stall, 1);
        chk("flush_idle_read", dcache_read, 0);
        chk("flush_rdata", rdata, 16'h5A5A);
        chk("flush_count", access_count, 6);

        // Zero-wait load brings the 3-bit counter to all-ones
        @(negedge clk); dcache_resp = 1'b1; dcache_rdata = 16'h0F0F; #1;
        chk("ld7_read", dcache_read, 1);
        chk("ld7_addr", dcache_address, 16'h7000);
        @(negedge clk); dcache_resp = 1'b0; dcache_rdata = '0; #1;
        chk("ld7_stall", stall, 0);
        chk("ld7_rdata", rdata, 16'h0F0F);
        chk("ld7_count", access_count, 7);
        valid = 1'b0;

        // One more access: counter saturates
        @(negedge clk); valid = 1'b1; addr = 16'h7002;
        @(negedge clk); dcache_resp = 1'b1; dcache_rdata = 16'h1111; #1;
        chk("sat_read", dcache_read, 1);
        @(negedge clk); dcache_resp = 1'b0; dcache_rdata = '0; #1;
        chk("sat_rdata", rdata, 16'h1111);
        chk("sat_count", access_count, 7);
        valid = 1'b0; mem_read = 1'b0;
        @(negedge clk); #1;
        chk("final_idle_stall", stall, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
